logger_ev_unpacker: RTL and testbench
=====================================

# logger_ev_unpacker

Reads the 56-byte ASCII log records produced by the event logger from a first-word-fall-through byte FIFO and reconstructs binary timestamp events (ID, start, end, delta). Each record is "IIII,SSSSSSSSSSSSSSSS,EEEEEEEEEEEEEEEE,DDDDDDDDDDDDDDDD\n", with uppercase hex fields, MSB nibble first. The block sits on the consumer side of the logging path, for loopback checking and for host-side replay into analysis logic. It checks format and delta consistency, and it resynchronises on the next newline after any framing error.

## Interface
- TS_W, 64, timestamp field width in bits; record carries TS_W/4 hex digits per timestamp
- ID_W, 16, event ID width in bits; record carries ID_W/4 hex digits
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- fifo_dout  in  8  current FIFO head byte (FWFT, valid when fifo_empty=0)
- fifo_empty  in  1  FIFO has no byte
- fifo_rd_en  out  1  pop head byte this cycle
- ev_valid  out  1  decoded event available
- ev_ready  in  1  downstream accepts event
- ev_id  out  ID_W  decoded ID
- ev_start  out  TS_W  decoded start timestamp
- ev_end  out  TS_W  decoded end timestamp
- ev_delta  out  TS_W  decoded delta
- ev_delta_err  out  1  ev_delta != (ev_end - ev_start) mod 2^TS_W; qualified by ev_valid
- err_pulse  out  1  one-cycle framing-error strobe
- err_code  out  2  1 = illegal byte, 2 = premature '\n'; held until next error
- err_count  out  16  framing errors since reset, saturating at 0xFFFF

## Operation
- States: ID, C1, START, C2, END, C3, DELTA, NL, OUT, RESYNC. Reset state is ID.
- A byte is consumed when fifo_rd_en=1. fifo_rd_en = !fifo_empty && state not in {OUT}. It is combinational, and never asserted while fifo_empty=1.
- Hex field states (ID/START/END/DELTA) work as follows:
  - Accept '0'-'9', 'A'-'F' and 'a'-'f'.
  - Shift-accumulate: field <= {field[W-5:0], nibble}.
  - A digit counter loads ID_W/4-1 or TS_W/4-1 on field entry. The final digit advances to the next state (C1/C2/C3/NL).
- Comma states (C1/C2/C3) require 0x2C. NL requires 0x0A.
- NL accepted leads to OUT:
  - ev_valid=1 and ev_delta_err is computed from the registered fields.
  - Outputs hold stable until ev_valid && ev_ready, then the block goes to ID.
- Illegal byte (any unexpected byte other than 0x0A) in ID..NL:
  - err_pulse=1, err_code=1, err_count+1.
  - Go to RESYNC, which discards bytes until 0x0A is consumed, then goes to ID.
  - Further errors are not counted while in RESYNC.
- 0x0A consumed in ID..DELTA or C1..C3 (premature newline):
  - err_pulse=1, err_code=2, err_count+1.
  - Go directly to ID. The newline counts as the terminator.
- Partial records never produce ev_valid.
- Field registers are cleared on entry to ID.

## Timing
- At most 1 byte per cycle, so a record takes at least 56 consumed cycles.
- ev_valid rises on the cycle after the '\n' pop. The earliest next-record pop is the cycle after the ev_valid/ev_ready handshake. Minimum 57 cycles per record.
- No bytes are consumed while ev_valid=1 (no skid buffer); backpressure propagates directly to the FIFO.
- fifo_empty gaps stall the parser without state change.
- err_pulse asserts in the cycle after the offending byte is popped.
- Reset (asynchronous, any time including mid-record or in OUT) forces these values:
  - state=ID, ev_valid=0, ev_delta_err=0, all ev_* fields=0.
  - err_pulse=0, err_code=0, err_count=0.
  - fifo_rd_en follows fifo_empty combinationally once reset deasserts.
- Delta check uses TS_W-bit modular subtraction, so end<start wraps legally.

## Test plan
- Decode one record: stream "12AB,0000000000000010,0000000000000035,0000000000000025\n" with ev_ready=1.
  - Expect one ev_valid cycle with ev_id=0x12AB, ev_start=0x10, ev_end=0x35, ev_delta=0x25, ev_delta_err=0.
  - Expect 56 pops and err_count=0.
- Backpressure: hold ev_ready=0 for 10 cycles with a second record queued.
  - fifo_rd_en stays 0 and the outputs stay stable.
  - After ev_ready=1 the second record decodes correctly.
  - Random fifo_empty gaps do not corrupt either record.
- Illegal byte: 'G' at START digit 5.
  - err_pulse for 1 cycle, err_code=1, err_count=1.
  - Remaining bytes through '\n' are discarded and the following valid record decodes.
- Premature newline: '\n' after 10 START digits.
  - err_code=2, err_count=1, no ev_valid.
  - The immediately following record decodes with no bytes lost.
- Delta check: start=FFFFFFFFFFFFFFF0, end=0000000000000010.
  - delta=0000000000000020 gives ev_delta_err=0.
  - delta=0000000000000021 gives ev_delta_err=1; the event is still emitted.
  - Lowercase "12ab" decodes as ID 0x12AB.
- Reset: assert rst asynchronously mid-END field and during OUT.
  - All outputs clear immediately.
  - The next complete record decodes correctly.
  - err_count saturates at 0xFFFF after 65536+ forced errors.

Source files
------------

// File: rtl/logger_ev_unpacker.sv
// Parses 56-byte ASCII event records ("IIII,SSSS...,EEEE...,DDDD...\n") from a FWFT byte FIFO
// back into binary events, flagging framing errors and start/end/delta inconsistency.
module logger_ev_unpacker #(
   parameter int TS_W = 64,
   parameter int ID_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      fifo_dout,
   input  logic            fifo_empty,
   output logic            fifo_rd_en,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [ID_W-1:0] ev_id,
   output logic [TS_W-1:0] ev_start,
   output logic [TS_W-1:0] ev_end,
   output logic [TS_W-1:0] ev_delta,
   output logic            ev_delta_err,
   output logic            err_pulse,
   output logic [1:0]      err_code,
   output logic [15:0]     err_count
);

   localparam int ID_DIG  = ID_W / 4;
   localparam int TS_DIG  = TS_W / 4;
   localparam int MAX_DIG = (TS_DIG > ID_DIG) ? TS_DIG : ID_DIG;
   localparam int DCNT_W  = (MAX_DIG > 1) ? $clog2(MAX_DIG) : 1;
   localparam logic [DCNT_W-1:0] ID_LOAD = DCNT_W'(ID_DIG - 1);
   localparam logic [DCNT_W-1:0] TS_LOAD = DCNT_W'(TS_DIG - 1);

   localparam logic [3:0] ST_ID     = 4'd0;
   localparam logic [3:0] ST_C1     = 4'd1;
   localparam logic [3:0] ST_START  = 4'd2;
   localparam logic [3:0] ST_C2     = 4'd3;
   localparam logic [3:0] ST_END    = 4'd4;
   localparam logic [3:0] ST_C3     = 4'd5;
   localparam logic [3:0] ST_DELTA  = 4'd6;
   localparam logic [3:0] ST_NL     = 4'd7;
   localparam logic [3:0] ST_OUT    = 4'd8;
   localparam logic [3:0] ST_RESYNC = 4'd9;

   logic [3:0]      state_reg, state_next;
   logic [DCNT_W-1:0] dcnt_reg, dcnt_next;
   logic [ID_W-1:0] id_reg, id_next;
   logic [TS_W-1:0] start_reg, start_next;
   logic [TS_W-1:0] end_reg, end_next;
   logic [TS_W-1:0] delta_reg, delta_next;
   logic            ev_valid_reg, ev_valid_next;
   logic            derr_reg, derr_next;
   logic            err_pulse_reg, err_pulse_next;
   logic [1:0]      err_code_reg, err_code_next;
   logic [15:0]     err_count_reg, err_count_next;

   logic            is_hex, is_nl, is_comma;
   logic [3:0]      nibble;
   logic            clear_fields, bad_byte, early_nl;

   // Nothing is popped while an event is waiting; backpressure goes straight to the FIFO.
   assign fifo_rd_en = !rst && !fifo_empty && (state_reg != ST_OUT);

   assign is_nl    = (fifo_dout == 8'h0A);
   assign is_comma = (fifo_dout == 8'h2C);

   // Letters A-F / a-f share low nibbles 1..6, so +9 maps both cases to 10..15.
   always_comb begin
      is_hex = 1'b0;
      nibble = fifo_dout[3:0];
      if (fifo_dout >= 8'h30 && fifo_dout <= 8'h39) begin
         is_hex = 1'b1;
      end else if ((fifo_dout >= 8'h41 && fifo_dout <= 8'h46) ||
                   (fifo_dout >= 8'h61 && fifo_dout <= 8'h66)) begin
         is_hex = 1'b1;
         nibble = fifo_dout[3:0] + 4'd9;
      end
   end

   always_comb begin
      state_next     = state_reg;
      dcnt_next      = dcnt_reg;
      id_next        = id_reg;
      start_next     = start_reg;
      end_next       = end_reg;
      delta_next     = delta_reg;
      ev_valid_next  = ev_valid_reg;
      derr_next      = derr_reg;
      err_pulse_next = 1'b0;
      err_code_next  = err_code_reg;
      err_count_next = err_count_reg;
      clear_fields   = 1'b0;
      bad_byte       = 1'b0;
      early_nl       = 1'b0;

      case (state_reg)
         ST_ID, ST_START, ST_END, ST_DELTA: begin
            if (fifo_rd_en) begin
               if (is_hex) begin
                  case (state_reg)
                     ST_ID:    id_next    = {id_reg[ID_W-5:0], nibble};
                     ST_START: start_next = {start_reg[TS_W-5:0], nibble};
                     ST_END:   end_next   = {end_reg[TS_W-5:0], nibble};
                     default:  delta_next = {delta_reg[TS_W-5:0], nibble};
                  endcase
                  if (dcnt_reg == '0) begin
                     case (state_reg)
                        ST_ID:    state_next = ST_C1;
                        ST_START: state_next = ST_C2;
                        ST_END:   state_next = ST_C3;
                        default:  state_next = ST_NL;
                     endcase
                  end else begin
                     dcnt_next = dcnt_reg - 1'b1;
                  end
               end else if (is_nl) begin
                  early_nl = 1'b1;
               end else begin
                  bad_byte = 1'b1;
               end
            end
         end
         ST_C1, ST_C2, ST_C3: begin
            if (fifo_rd_en) begin
               if (is_comma) begin
                  dcnt_next = TS_LOAD;
                  case (state_reg)
                     ST_C1:   state_next = ST_START;
                     ST_C2:   state_next = ST_END;
                     default: state_next = ST_DELTA;
                  endcase
               end else if (is_nl) begin
                  early_nl = 1'b1;
               end else begin
                  bad_byte = 1'b1;
               end
            end
         end
         ST_NL: begin
            if (fifo_rd_en) begin
               if (is_nl) begin
                  state_next    = ST_OUT;
                  ev_valid_next = 1'b1;
                  derr_next     = (delta_reg != (end_reg - start_reg));
               end else begin
                  bad_byte = 1'b1;
               end
            end
         end
         ST_OUT: begin
            if (ev_ready) begin
               state_next    = ST_ID;
               ev_valid_next = 1'b0;
               derr_next     = 1'b0;
               clear_fields  = 1'b1;
            end
         end
         ST_RESYNC: begin
            if (fifo_rd_en && is_nl) begin
               state_next   = ST_ID;
               clear_fields = 1'b1;
            end
         end
         default: begin
            state_next   = ST_ID;
            clear_fields = 1'b1;
         end
      endcase

      // A premature newline doubles as the record terminator, so it returns straight to ID.
      if (early_nl || bad_byte) begin
         err_pulse_next = 1'b1;
         err_code_next  = early_nl ? 2'd2 : 2'd1;
         if (err_count_reg != 16'hFFFF)
            err_count_next = err_count_reg + 16'd1;
         state_next   = early_nl ? ST_ID : ST_RESYNC;
         clear_fields = early_nl;
      end

      if (clear_fields) begin
         id_next    = '0;
         start_next = '0;
         end_next   = '0;
         delta_next = '0;
         dcnt_next  = ID_LOAD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_ID;
         dcnt_reg      <= ID_LOAD;
         id_reg        <= '0;
         start_reg     <= '0;
         end_reg       <= '0;
         delta_reg     <= '0;
         ev_valid_reg  <= 1'b0;
         derr_reg      <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_code_reg  <= 2'd0;
         err_count_reg <= 16'd0;
      end else begin
         state_reg     <= state_next;
         dcnt_reg      <= dcnt_next;
         id_reg        <= id_next;
         start_reg     <= start_next;
         end_reg       <= end_next;
         delta_reg     <= delta_next;
         ev_valid_reg  <= ev_valid_next;
         derr_reg      <= derr_next;
         err_pulse_reg <= err_pulse_next;
         err_code_reg  <= err_code_next;
         err_count_reg <= err_count_next;
      end
   end

   assign ev_valid     = ev_valid_reg;
   assign ev_id        = id_reg;
   assign ev_start     = start_reg;
   assign ev_end       = end_reg;
   assign ev_delta     = delta_reg;
   assign ev_delta_err = derr_reg;
   assign err_pulse    = err_pulse_reg;
   assign err_code     = err_code_reg;
   assign err_count    = err_count_reg;

endmodule

// File: tb/tb_logger_ev_unpacker.sv
// Scoreboard bench for logger_ev_unpacker: records are built as bytes, expected events/errors
// are queued at push time and compared when the DUT raises ev_valid / err_pulse.
module tb_logger_ev_unpacker;
   localparam int TS_W = 64;
   localparam int ID_W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [7:0]      fifo_dout;
   logic            fifo_empty;
   logic            fifo_rd_en;
   logic            ev_valid;
   logic            ev_ready;
   logic [ID_W-1:0] ev_id;
   logic [TS_W-1:0] ev_start, ev_end, ev_delta;
   logic            ev_delta_err;
   logic            err_pulse;
   logic [1:0]      err_code;
   logic [15:0]     err_count;

   typedef struct {
      logic [15:0] id;
      logic [63:0] st;
      logic [63:0] en;
      logic [63:0] dl;
      logic        derr;
   } ev_t;

   logic [7:0] byte_q[$];
   ev_t        exp_ev_q[$];
   logic [1:0] exp_err_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         pops = 0;
   bit         gap_en = 1'b0;
   logic [15:0] exp_cnt = 16'd0;

   always #5 clk = ~clk;

   logger_ev_unpacker #(.TS_W(TS_W), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_id(ev_id), .ev_start(ev_start), .ev_end(ev_end), .ev_delta(ev_delta),
      .ev_delta_err(ev_delta_err), .err_pulse(err_pulse), .err_code(err_code),
      .err_count(err_count)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] hx(input logic [3:0] n, input bit lower);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return (lower ? 8'h57 : 8'h37) + {4'h0, n};
   endfunction

   task automatic push_field(input logic [63:0] v, input int digits, input bit lower);
      for (int i = digits - 1; i >= 0; i--) byte_q.push_back(hx(v[i*4 +: 4], lower));
   endtask

   task automatic push_rec(input logic [15:0] id, input logic [63:0] st, input logic [63:0] en,
                           input logic [63:0] dl, input bit lower);
      ev_t e;
      push_field({48'h0, id}, 4, lower); byte_q.push_back(8'h2C);
      push_field(st, 16, lower);         byte_q.push_back(8'h2C);
      push_field(en, 16, lower);         byte_q.push_back(8'h2C);
      push_field(dl, 16, lower);         byte_q.push_back(8'h0A);
      e.id = id; e.st = st; e.en = en; e.dl = dl;
      e.derr = (dl != (en - st));
      exp_ev_q.push_back(e);
   endtask

   // FWFT FIFO model: pop on the edge where rd_en is seen, present the new head 1 unit later.
   initial begin
      fifo_empty = 1'b1;
      fifo_dout  = 8'h00;
      forever begin
         @(posedge clk);
         if (fifo_rd_en && !fifo_empty && byte_q.size() > 0) begin
            void'(byte_q.pop_front());
            pops++;
         end
         #1;
         if (byte_q.size() == 0 || (gap_en && $urandom_range(0, 3) == 0)) begin
            fifo_empty = 1'b1;
            fifo_dout  = 8'h00;
         end else begin
            fifo_empty = 1'b0;
            fifo_dout  = byte_q[0];
         end
      end
   end

   // Output monitor
   initial begin
      bit  ev_seen;
      ev_t e;
      logic [1:0] c;
      ev_seen = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            ev_seen = 1'b0;
         end else begin
            if (!ev_valid) begin
               ev_seen = 1'b0;
            end else if (!ev_seen) begin
               ev_seen = 1'b1;
               check("ev_expected", 64'(exp_ev_q.size() > 0), 64'd1);
               if (exp_ev_q.size() > 0) begin
                  e = exp_ev_q.pop_front();
                  $display("event id=%h start=%h end=%h delta=%h derr=%0b",
                           ev_id, ev_start, ev_end, ev_delta, ev_delta_err);
                  check("ev_id", 64'(ev_id), 64'(e.id));
                  check("ev_start", ev_start, e.st);
                  check("ev_end", ev_end, e.en);
                  check("ev_delta", ev_delta, e.dl);
                  check("ev_delta_err", 64'(ev_delta_err), 64'(e.derr));
               end
            end
            if (err_pulse) begin
               check("err_expected", 64'(exp_err_q.size() > 0), 64'd1);
               if (exp_err_q.size() > 0) begin
                  c = exp_err_q.pop_front();
                  if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                  check("err_code", 64'(err_code), 64'(c));
                  check("err_count", 64'(err_count), 64'(exp_cnt));
               end
            end
         end
      end
   end

   task automatic wait_drain(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (byte_q.size() == 0 && exp_ev_q.size() == 0 && exp_err_q.size() == 0 && !ev_valid)
            done = 1'b1;
      end
      check("drain_done", 64'(done), 64'd1);
   endtask

   task automatic wait_ev(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (ev_valid) done = 1'b1;
      end
      check("ev_arrived", 64'(done), 64'd1);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_valid", 64'(ev_valid), 64'd0);
      check("rst_start", ev_start, 64'd0);
      check("rst_id", 64'(ev_id), 64'd0);
      check("rst_derr", 64'(ev_delta_err), 64'd0);
      check("rst_errcnt", 64'(err_count), 64'd0);
      check("rst_errcode", 64'(err_code), 64'd0);
      byte_q.delete();
      exp_ev_q.delete();
      exp_err_q.delete();
      exp_cnt = 16'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ev_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_valid", 64'(ev_valid), 64'd0);
      check("reset_errcnt", 64'(err_count), 64'd0);
      check("reset_errpulse", 64'(err_pulse), 64'd0);
      check("reset_rd_en_empty", 64'(fifo_rd_en), 64'd0);

      // single record, count pops
      pops = 0;
      push_rec(16'h12AB, 64'h10, 64'h35, 64'h25, 1'b0);
      wait_drain(300);
      check("pops_one_record", 64'(pops), 64'd56);
      check("errcnt_clean", 64'(err_count), 64'd0);

      // backpressure with a second record queued, random gaps
      gap_en = 1'b1;
      ev_ready = 1'b0;
      push_rec(16'h0BEE, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_5555, 64'h1111, 1'b0);
      push_rec(16'hC0DE, 64'h5, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      wait_ev(600);
      repeat (10) begin
         @(negedge clk);
         check("bp_rd_en", 64'(fifo_rd_en), 64'd0);
         check("bp_valid", 64'(ev_valid), 64'd1);
         check("bp_id", 64'(ev_id), 64'h0BEE);
         check("bp_end", ev_end, 64'h1111_2222_3333_5555);
      end
      ev_ready = 1'b1;
      wait_drain(800);

      // illegal 'G' at START digit 5, then a good record
      push_field(64'h1234, 4, 1'b0); byte_q.push_back(8'h2C);
      push_field(64'h0123, 4, 1'b0); byte_q.push_back(8'h47);
      push_field(64'h0, 11, 1'b0);   byte_q.push_back(8'h2C);
      push_field(64'hAB, 16, 1'b0);  byte_q.push_back(8'h2C);
      push_field(64'hCD, 16, 1'b0);  byte_q.push_back(8'h0A);
      exp_err_q.push_back(2'd1);
      push_rec(16'h0042, 64'h100, 64'h180, 64'h80, 1'b0);
      wait_drain(800);
      check("illegal_errcnt", 64'(err_count), 64'd1);

      // premature newline after 10 START digits
      push_field(64'hABCD, 4, 1'b0); byte_q.push_back(8'h2C);
      push_field(64'h12_3456_789A, 10, 1'b0); byte_q.push_back(8'h0A);
      exp_err_q.push_back(2'd2);
      push_rec(16'h7777, 64'h1, 64'h2, 64'h1, 1'b0);
      wait_drain(800);
      check("early_nl_code", 64'(err_code), 64'd2);
      check("early_nl_errcnt", 64'(err_count), 64'd2);

      // delta wrap, delta error, lowercase
      push_rec(16'h12AB, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h20, 1'b1);
      push_rec(16'h12AB, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'h21, 1'b0);
      wait_drain(800);
      gap_en = 1'b0;

      // async reset mid-END field
      pops = 0;
      push_rec(16'h5A5A, 64'hDEAD_BEEF, 64'hFEED_F00D, 64'h1, 1'b0);
      for (int i = 0; i < 200 && pops < 30; i++) @(negedge clk);
      check("mid_end_reached", 64'(pops >= 30), 64'd1);
      async_reset();
      push_rec(16'h0101, 64'h20, 64'h30, 64'h10, 1'b0);
      wait_drain(300);

      // async reset while holding an event in OUT
      ev_ready = 1'b0;
      push_rec(16'hBEEF, 64'h40, 64'h50, 64'h11, 1'b0);
      wait_ev(300);
      async_reset();
      ev_ready = 1'b1;
      push_rec(16'h0202, 64'h7, 64'h9, 64'h2, 1'b0);
      wait_drain(300);

      // err_count saturation via back-to-back premature newlines
      for (int i = 0; i < 65540; i++) begin
         byte_q.push_back(8'h0A);
         exp_err_q.push_back(2'd2);
      end
      wait_drain(70000);
      check("sat_errcnt", 64'(err_count), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
